// File: rtl/noc_flit_sink_pkg.sv
// Shared flit-sink definitions: flit type codes, link widths, error causes, FSM states.
// Compile first; imported by every other file of the sink.
package noc_flit_sink_pkg;

    localparam int PAYLOAD_W = 64;
    localparam int TYPE_W    = 3;
    localparam int VCH_W     = 1;

    localparam int TYPE_NONE = 0;
    localparam int TYPE_HEAD = 1;
    localparam int TYPE_DATA = 2;
    localparam int TYPE_TAIL = 3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_IDLE    = 2'd1;
    localparam logic [1:0] ERR_BODY    = 2'd2;
    localparam logic [1:0] ERR_VCH_LEN = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

endpackage

// File: rtl/noc_flit_sink_sat_counter.sv
// Purpose: statistics counter that adds a per-cycle increment and sticks at all-ones.
// Latency: one cycle from increment to count; clear wins over increment.
// Backpressure: none, an increment is absorbed every cycle.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             clear,
    input  logic [CNT_W-1:0] inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W:0] sum;

    assign sum = {1'b0, cnt} + {1'b0, inc};

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (sum[CNT_W]) begin
            cnt <= '1;
        end else begin
            cnt <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/noc_flit_sink.sv
// Purpose: flit link sink checking HEAD/DATA/TAIL framing, returning credits, keeping stats (toggle stats under FLIT_SINK_TOGGLE_EN).
// Latency: credit and every statistic/error update appear one cycle after the flit is sampled.
// Backpressure: never stalls; every valid flit is accepted and credited, including errored ones.
module noc_flit_sink #(
    parameter int PAYLOAD_W = 64,
    parameter int TYPE_W    = 3,
    parameter int VCH_W     = 1,
    parameter int CNT_W     = 32,
    parameter int MAX_LEN   = 64
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [TYPE_W+PAYLOAD_W-1:0] idata,
    input  logic                      ivalid,
    input  logic [VCH_W-1:0]          ivch,
    input  logic                      count_en,
    input  logic                      clear,
    output logic                      ocredit,
    output logic [VCH_W-1:0]          ocredit_vch,
    output logic [CNT_W-1:0]          pkt_cnt,
    output logic [CNT_W-1:0]          flit_cnt,
    output logic [CNT_W-1:0]          busy_cnt,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [CNT_W-1:0]          toggle_cnt,
    output logic [7:0]                last_len,
    output logic                      err,
    output logic [1:0]                err_code
);

    import noc_flit_sink_pkg::*;

    localparam int LEN_W = 16;

    logic [TYPE_W-1:0]    ftype;
    logic [PAYLOAD_W-1:0] payload;
    state_t               state, state_nxt;
    logic [VCH_W-1:0]     pkt_vch, pkt_vch_nxt;
    logic [LEN_W-1:0]     len, len_nxt, len_inc;
    logic                 flt_err, pkt_done;
    logic [1:0]           flt_code;
    logic [CNT_W-1:0]     flit_inc, cycle_inc, pkt_inc;

    assign ftype   = idata[TYPE_W+PAYLOAD_W-1:PAYLOAD_W];
    assign payload = idata[PAYLOAD_W-1:0];
    assign len_inc = len + LEN_W'(1);

    always_comb begin
        state_nxt   = state;
        pkt_vch_nxt = pkt_vch;
        len_nxt     = len;
        flt_err     = 1'b0;
        flt_code    = ERR_NONE;
        pkt_done    = 1'b0;
        if (clear) begin
            state_nxt = ST_IDLE;
            len_nxt   = '0;
        end else if (ivalid) begin
            case (state)
                ST_IDLE: begin
                    if (ftype == TYPE_W'(TYPE_HEAD)) begin
                        state_nxt   = ST_BODY;
                        pkt_vch_nxt = ivch;
                        len_nxt     = LEN_W'(1);
                    end else begin
                        flt_err  = 1'b1;
                        flt_code = ERR_IDLE;
                    end
                end
                default: begin
                    len_nxt = len_inc;
                    if (ftype != TYPE_W'(TYPE_DATA) && ftype != TYPE_W'(TYPE_TAIL)) begin
                        flt_err  = 1'b1;
                        flt_code = ERR_BODY;
                    end else if (ivch != pkt_vch) begin
                        flt_err  = 1'b1;
                        flt_code = ERR_VCH_LEN;
                    end else if (ftype == TYPE_W'(TYPE_TAIL)) begin
                        state_nxt = ST_IDLE;
                        pkt_done  = 1'b1;
                    end else if (len_inc >= LEN_W'(MAX_LEN)) begin
                        // a DATA reaching MAX_LEN leaves no room for the TAIL
                        flt_err  = 1'b1;
                        flt_code = ERR_VCH_LEN;
                    end
                    if (flt_err) begin
                        state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= ST_IDLE;
            pkt_vch <= '0;
            len     <= '0;
        end else begin
            state   <= state_nxt;
            pkt_vch <= pkt_vch_nxt;
            len     <= len_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ocredit     <= 1'b0;
            ocredit_vch <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            last_len    <= '0;
        end else begin
            ocredit     <= ivalid;
            ocredit_vch <= ivalid ? ivch : '0;
            if (clear) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
                last_len <= '0;
            end else begin
                if (flt_err && !err) begin
                    err      <= 1'b1;
                    err_code <= flt_code;
                end
                if (pkt_done && count_en) begin
                    last_len <= (len_inc > LEN_W'(255)) ? 8'hFF : len_inc[7:0];
                end
            end
        end
    end

    assign flit_inc  = (count_en && ivalid) ? CNT_W'(1) : '0;
    assign cycle_inc = count_en ? CNT_W'(1) : '0;
    assign pkt_inc   = (count_en && pkt_done) ? CNT_W'(1) : '0;

    sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
        .clk(clk), .rst_(rst_), .clear(clear), .inc(pkt_inc), .cnt(pkt_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flit_cnt (
        .clk(clk), .rst_(rst_), .clear(clear), .inc(flit_inc), .cnt(flit_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_busy_cnt (
        .clk(clk), .rst_(rst_), .clear(clear), .inc(flit_inc), .cnt(busy_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk(clk), .rst_(rst_), .clear(clear), .inc(cycle_inc), .cnt(cycle_cnt)
    );

`ifdef FLIT_SINK_TOGGLE_EN
    localparam int POP_W = $clog2(PAYLOAD_W + 1);

    logic [PAYLOAD_W-1:0] prev_payload;
    logic [POP_W-1:0]     pop;
    logic [CNT_W-1:0]     pop_sat, toggle_inc;

    function automatic logic [POP_W-1:0] popcount(input logic [PAYLOAD_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < PAYLOAD_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prev_payload <= '0;
        end else begin
            prev_payload <= payload;
        end
    end

    assign pop = popcount(payload ^ prev_payload);

    // a narrow counter must not see a truncated (wrapped) increment
    if (CNT_W >= POP_W) begin : g_pop_fit
        assign pop_sat = CNT_W'(pop);
    end else begin : g_pop_clip
        assign pop_sat = (pop > POP_W'({CNT_W{1'b1}})) ? '1 : pop[CNT_W-1:0];
    end

    assign toggle_inc = count_en ? pop_sat : '0;

    sat_counter #(.CNT_W(CNT_W)) u_toggle_cnt (
        .clk(clk), .rst_(rst_), .clear(clear), .inc(toggle_inc), .cnt(toggle_cnt)
    );
`else
    logic unused_payload;

    assign unused_payload = ^payload;
    assign toggle_cnt     = '0;
`endif

endmodule

// File: tb/tb_noc_flit_sink.sv
// Directed bench for noc_flit_sink: framing, sweep, errors, toggles, reset/clear and a CNT_W=4 saturation copy.
module tb_noc_flit_sink;

    localparam int PW = 64;
    localparam int TW = 3;
    localparam int VW = 1;
    localparam logic [2:0] T_HEAD = 3'd1;
    localparam logic [2:0] T_DATA = 3'd2;
    localparam logic [2:0] T_TAIL = 3'd3;

    logic            clk = 1'b0;
    logic            rst_;
    logic [TW+PW-1:0] idata;
    logic            ivalid;
    logic [VW-1:0]   ivch;
    logic            count_en;
    logic            clear;

    logic            ocredit;
    logic [VW-1:0]   ocredit_vch;
    logic [31:0]     pkt_cnt, flit_cnt, busy_cnt, cycle_cnt, toggle_cnt;
    logic [7:0]      last_len;
    logic            err;
    logic [1:0]      err_code;

    logic            s_ocredit;
    logic [VW-1:0]   s_ocredit_vch;
    logic [3:0]      s_pkt_cnt, s_flit_cnt, s_busy_cnt, s_cycle_cnt, s_toggle_cnt;
    logic [7:0]      s_last_len;
    logic            s_err;
    logic [1:0]      s_err_code;

    int n_checks = 0;
    int n_errors = 0;
    int cred_cnt = 0;
    int cred_vch1 = 0;
    int base_cred;
    int base_vch1;

    noc_flit_sink dut (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .count_en(count_en), .clear(clear),
        .ocredit(ocredit), .ocredit_vch(ocredit_vch),
        .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt), .busy_cnt(busy_cnt),
        .cycle_cnt(cycle_cnt), .toggle_cnt(toggle_cnt),
        .last_len(last_len), .err(err), .err_code(err_code)
    );

    noc_flit_sink #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .count_en(count_en), .clear(clear),
        .ocredit(s_ocredit), .ocredit_vch(s_ocredit_vch),
        .pkt_cnt(s_pkt_cnt), .flit_cnt(s_flit_cnt), .busy_cnt(s_busy_cnt),
        .cycle_cnt(s_cycle_cnt), .toggle_cnt(s_toggle_cnt),
        .last_len(s_last_len), .err(s_err), .err_code(s_err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ocredit) begin
            cred_cnt++;
            if (ocredit_vch == 1'b1) cred_vch1++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [2:0] t, input logic [63:0] p, input logic [VW-1:0] v);
        idata  = {t, p};
        ivch   = v;
        ivalid = 1'b1;
        tick(1);
        ivalid = 1'b0;
    endtask

    task automatic packet(input int ndata, input logic [VW-1:0] v);
        send(T_HEAD, 64'h0, v);
        for (int i = 0; i < ndata; i++) send(T_DATA, 64'(i), v);
        send(T_TAIL, 64'h0, v);
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        rst_     = 1'b0;
        idata    = '0;
        ivalid   = 1'b0;
        ivch     = '0;
        count_en = 1'b1;
        clear    = 1'b0;
        tick(3);
        check("rst_flit_cnt", flit_cnt, 0);
        check("rst_ocredit", ocredit, 0);
        check("rst_err", err, 0);
        rst_ = 1'b1;
        tick(1);

        // toggles: payloads 0, ones, 0, 0x0F from reset
        send(T_HEAD, 64'h0, 1'b0);
        send(T_DATA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(T_DATA, 64'h0, 1'b0);
        send(T_TAIL, 64'h0F, 1'b0);
`ifdef FLIT_SINK_TOGGLE_EN
        check("toggle_cnt", toggle_cnt, 132);
`else
        check("toggle_cnt", toggle_cnt, 0);
`endif
        check("toggle_pkt_cnt", pkt_cnt, 1);
        check("toggle_last_len", last_len, 4);

        // framing
        pulse_clear();
        base_cred = cred_cnt;
        base_vch1 = cred_vch1;
        packet(20, 1'b0);
        tick(2);
        check("frame_pkt_cnt", pkt_cnt, 1);
        check("frame_flit_cnt", flit_cnt, 22);
        check("frame_busy_cnt", busy_cnt, 22);
        check("frame_last_len", last_len, 22);
        check("frame_credits", cred_cnt - base_cred, 22);
        check("frame_credit_vch1", cred_vch1 - base_vch1, 0);
        check("frame_err", err, 0);
        check("sat_flit_cnt", s_flit_cnt, 15);
        check("sat_busy_cnt", s_busy_cnt, 15);

        // traffic sweep
        pulse_clear();
        for (int p = 0; p < 10; p++) begin
            packet(20, 1'b0);
            tick(7);
        end
        check("sweep_pkt_cnt", pkt_cnt, 10);
        check("sweep_flit_cnt", flit_cnt, 220);
        check("sweep_busy_cnt", busy_cnt, 220);
        check("sweep_cycle_ge_290", cycle_cnt >= 290, 1);

        // DATA in IDLE
        pulse_clear();
        send(T_DATA, 64'h1, 1'b0);
        check("e1_err", err, 1);
        check("e1_code", err_code, 1);
        check("e1_pkt_cnt", pkt_cnt, 0);

        // HEAD inside a packet
        pulse_clear();
        send(T_HEAD, 64'h0, 1'b0);
        send(T_DATA, 64'h0, 1'b0);
        send(T_HEAD, 64'h0, 1'b0);
        check("e2_code", err_code, 2);
        send(T_TAIL, 64'h0, 1'b0);
        check("e2_sticky_code", err_code, 2);
        check("e2_pkt_cnt", pkt_cnt, 0);

        // VC mismatch inside a packet
        pulse_clear();
        base_vch1 = cred_vch1;
        send(T_HEAD, 64'h0, 1'b0);
        send(T_DATA, 64'h0, 1'b1);
        check("e3_code", err_code, 3);
        check("e3_ocredit_vch", ocredit_vch, 1);
        tick(1);
        check("e3_credit_vch1", cred_vch1 - base_vch1, 1);
        check("e3_pkt_cnt", pkt_cnt, 0);

        // counters frozen, credits and checking alive
        pulse_clear();
        count_en  = 1'b0;
        base_cred = cred_cnt;
        send(T_HEAD, 64'h0, 1'b0);
        send(T_TAIL, 64'h0, 1'b0);
        tick(1);
        check("noen_flit_cnt", flit_cnt, 0);
        check("noen_pkt_cnt", pkt_cnt, 0);
        check("noen_credits", cred_cnt - base_cred, 2);
        check("noen_err", err, 0);
        count_en = 1'b1;

        // asynchronous reset mid-packet
        pulse_clear();
        send(T_HEAD, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) send(T_DATA, 64'h0, 1'b0);
        check("pre_rst_flit_cnt", flit_cnt, 6);
        rst_ = 1'b0;
        #1;
        check("arst_flit_cnt", flit_cnt, 0);
        check("arst_ocredit", ocredit, 0);
        check("arst_cycle_cnt", cycle_cnt, 0);
        #2;
        rst_ = 1'b1;
        send(T_TAIL, 64'h0, 1'b0);
        check("arst_tail_code", err_code, 1);

        // clear with a simultaneous HEAD
        tick(2);
        base_cred = cred_cnt;
        clear  = 1'b1;
        idata  = {T_HEAD, 64'h0};
        ivch   = 1'b0;
        ivalid = 1'b1;
        tick(1);
        clear  = 1'b0;
        ivalid = 1'b0;
        check("clr_flit_cnt", flit_cnt, 0);
        check("clr_err", err, 0);
        check("clr_ocredit", ocredit, 1);
        send(T_DATA, 64'h0, 1'b0);
        check("clr_data_code", err_code, 1);
        check("clr_data_flit_cnt", flit_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/noc_flit_sink.md
Name: noc_flit_sink

Overview:
- Receive-side endpoint for the router flit link driven by the output-port mux (odata/ovalid/ovch).
- Accepts every valid flit and checks HEAD→DATA*→TAIL framing per link.
- Returns one credit per accepted flit and accumulates characterization statistics: packets, flits, busy cycles and payload bit toggles.
- Used in energy/utilization characterization benches and as the terminal sink of a router output port.

Parameters:
- PAYLOAD_W, 64, payload bits per flit.
- TYPE_W, 3, flit type field width; the type field is the flit MSBs.
- VCH_W, 1, virtual-channel id width.
- CNT_W, 32, width of every statistics counter.
- MAX_LEN, 64, maximum legal packet length in flits, HEAD and TAIL included.

Ports:
- clk  in  1  clock.
- rst_  in  1  asynchronous active-low reset.
- idata  in  TYPE_W+PAYLOAD_W  flit: {type, payload}.
- ivalid  in  1  flit valid; sampled every rising edge.
- ivch  in  VCH_W  flit virtual channel.
- count_en  in  1  statistics gate.
- clear  in  1  synchronous clear of counters and error state.
- ocredit  out  1  one-cycle credit pulse.
- ocredit_vch  out  VCH_W  VC of the returned credit.
- pkt_cnt  out  CNT_W  completed packets.
- flit_cnt  out  CNT_W  accepted flits.
- busy_cnt  out  CNT_W  cycles with ivalid=1.
- cycle_cnt  out  CNT_W  cycles with count_en=1.
- toggle_cnt  out  CNT_W  accumulated payload Hamming distance.
- last_len  out  8  length of the last completed packet.
- err  out  1  sticky protocol error.
- err_code  out  2  first error cause.

Behaviour:
- Reset (async, rst_=0): all outputs 0, FSM in IDLE, prev-payload register 0.
- Type encoding: NONE=0, HEAD=1, DATA=2, TAIL=3. Values 4-7 are illegal.
- FSM, evaluated only on cycles with ivalid=1:
  - IDLE + HEAD → BODY; latch ivch as pkt_vch; len=1.
  - BODY + DATA → BODY; len+1.
  - BODY + TAIL → IDLE; len+1; last_len<=len+1; pkt_cnt+1.
  - ivalid=0: state held; idle bubbles inside a packet are legal.
- Errors. Only the first error sets err_code; err is sticky until clear or reset. On any error the FSM returns to IDLE; a HEAD that caused an error does not restart a packet.
  - err_code 1: DATA/TAIL/NONE/illegal type received in IDLE.
  - err_code 2: HEAD or illegal type received in BODY.
  - err_code 3: ivch≠pkt_vch in BODY, or len reaches MAX_LEN without TAIL.
- Credit:
  - Every ivalid=1 cycle produces ocredit=1 on the next cycle, with ocredit_vch = sampled ivch. This applies to errored flits too.
  - Back-to-back flits give continuous credit.
- Statistics, all gated by count_en, updated one cycle after sampling, saturating at 2^CNT_W-1 with no wrap:
  - flit_cnt +1 per valid flit.
  - busy_cnt +1 per ivalid cycle.
  - cycle_cnt +1 per count_en cycle.
  - pkt_cnt counts only error-free TAILs.
  - last_len saturates at 255.
- clear: synchronous; zeroes counters, err, err_code and last_len; FSM → IDLE. clear has priority over a simultaneous flit. That flit is still credited but not counted or checked.
- count_en=0: FSM, error checking and credits stay active; only counters freeze.

Optional Feature:
- Macro FLIT_SINK_TOGGLE_EN.
- Defined: each cycle with count_en=1, toggle_cnt += popcount(payload XOR prev_payload); prev_payload <= payload every cycle, regardless of ivalid.
- Not defined: toggle_cnt tied to 0; no prev-payload register or popcount logic is synthesized.

Decomposition:
- Shared package/define file holds: the TYPE_NONE/HEAD/DATA/TAIL constants, TYPE_W, PAYLOAD_W, VCH_W, err_code constants, and the FSM state encoding (IDLE=0, BODY=1).
- One sub-module, sat_counter (CNT_W, increment input of CNT_W, saturating), instantiated for each counter.
- The popcount is a function in the sink.

Test Plan:
- Framing: HEAD + 20 DATA + TAIL on vch 0, count_en=1 → pkt_cnt=1, flit_cnt=22, busy_cnt=22, last_len=22, 22 credit pulses with vch 0, err=0.
- Traffic sweep: 10 such packets each followed by 7 idle cycles → pkt_cnt=10, flit_cnt=220, busy_cnt=220, cycle_cnt ≥ 290.
- Protocol errors, each followed by clear:
  - DATA in IDLE → err=1, err_code=1.
  - HEAD, DATA, HEAD → err_code=2.
  - HEAD vch0, DATA vch1 → err_code=3, credit vch=1.
  - In all three cases pkt_cnt stays 0.
- Toggles (FLIT_SINK_TOGGLE_EN defined): valid payloads 0, all-ones, 0, 0x0F on consecutive cycles from reset → toggle_cnt=64+64+4=132. With the macro undefined → 0.
- Reset and clear:
  - rst_ low after HEAD + 5 DATA → all outputs 0 immediately.
  - A following TAIL → err_code=1.
  - Assert clear with a simultaneous HEAD → counters 0; next DATA → err_code=1.
- Saturation: CNT_W=4, 20 valid flits → flit_cnt=15, no wrap.
